// File: rtl/hs32_execute.sv
// HS32 stage-3 execute: ALU with NZCV flags, registered result slot for writeback.
// Define HS32_EX_MUL_EN to include the iterative radix-2 multiplier.
package hs32_pkg;
    typedef struct packed {
        logic       neg;
        logic       sub;
        logic       cen;
        logic [1:0] opr;
        logic       fwe;
    } hs32_aluctl;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [3:0]  rd;
        logic        we1;
        logic        we2;
        hs32_aluctl  ctl;
    } hs32_s2pkt;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  rd;
        logic        we1;
        logic        we2;
    } hs32_s3pkt;
endpackage

module hs32_execute
    import hs32_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       valid_i,
    output logic       ready_o,
    input  hs32_s2pkt  data_i,
    input  logic       mul_i,
    input  logic       flush_i,
    output logic       valid_o,
    input  logic       ready_i,
    output hs32_s3pkt  data_o,
    output logic [3:0] rd3_o,
    output logic       stl3_o,
    output logic [3:0] flags_o
);
    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        v;
    } alu_res_t;

    function automatic alu_res_t alu_eval(input hs32_s2pkt p, input logic c_flag);
        logic [31:0] b;
        logic        cin;
        logic [32:0] sum;
        alu_res_t    r;
        b   = p.ctl.neg ? ~p.d2 : p.d2;
        cin = p.ctl.cen ? c_flag : p.ctl.sub;
        sum = {1'b0, p.d1} + {1'b0, b} + {32'd0, cin};
        r.c = sum[32];
        r.v = (p.d1[31] == b[31]) & (sum[31] != p.d1[31]);
        case (p.ctl.opr)
            2'd0:    r.res = sum[31:0];
            2'd1:    r.res = p.d1 & b;
            2'd2:    r.res = p.d1 | b;
            default: r.res = p.d1 ^ b;
        endcase
        return r;
    endfunction

    // Flag word is {N,Z,C,V}; logical ops keep the previous C and V.
    function automatic logic [3:0] flags_next(input logic [3:0] f, input logic [31:0] res,
                                              input logic arith, input logic c, input logic v);
        return {res[31], res == 32'd0, arith ? c : f[1], arith ? v : f[0]};
    endfunction

    hs32_s3pkt  out_p1;
    logic       vld_p1;
    logic [3:0] flags_p1;

    logic       idle;
    logic       accept;
    logic       alu_acc;
    logic       mul_done;
    logic       mul_fwe;
    hs32_s3pkt  mul_out;
    alu_res_t   alu;

    assign alu     = alu_eval(data_i, flags_p1[1]);
    assign ready_o = idle & (~vld_p1 | ready_i);
    assign accept  = valid_i & ready_o & ~flush_i;

`ifdef HS32_EX_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;

    state_t      state_p0, state_nx;
    logic [31:0] mcand_p0, mplier_p0, acc_p0;
    logic [4:0]  cnt_p0;
    logic [3:0]  mrd_p0;
    logic        mwe1_p0, mwe2_p0, mfwe_p0;
    logic [31:0] acc_step;
    logic        mul_acc;
    logic        mul_step;

    assign idle     = (state_p0 == IDLE);
    assign mul_acc  = accept & mul_i;
    assign alu_acc  = accept & ~mul_i;
    assign acc_step = mplier_p0[0] ? acc_p0 + mcand_p0 : acc_p0;
    assign mul_out  = {acc_step, mrd_p0, mwe1_p0, mwe2_p0};
    assign mul_fwe  = mfwe_p0;

    // The last step waits until the output slot is free so its result is never lost.
    always_comb begin
        state_nx = state_p0;
        mul_step = 1'b0;
        mul_done = 1'b0;
        case (state_p0)
            IDLE: if (mul_acc) state_nx = MUL;
            MUL: begin
                if (cnt_p0 != 5'd0) begin
                    mul_step = 1'b1;
                end else if (~vld_p1 | ready_i) begin
                    mul_step = 1'b1;
                    mul_done = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (flush_i) begin
            state_nx = IDLE;
            mul_step = 1'b0;
            mul_done = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_p0 <= IDLE;
        else       state_p0 <= state_nx;
    end

    // ---- stage p0: multiplier datapath ----
    always_ff @(posedge clk) begin
        if (mul_acc) begin
            mcand_p0  <= data_i.d1;
            mplier_p0 <= data_i.d2;
            acc_p0    <= 32'd0;
            cnt_p0    <= 5'd31;
            mrd_p0    <= data_i.rd;
            mwe1_p0   <= data_i.we1;
            mwe2_p0   <= data_i.we2;
            mfwe_p0   <= data_i.ctl.fwe;
        end else if (mul_step) begin
            acc_p0    <= acc_step;
            mcand_p0  <= {mcand_p0[30:0], 1'b0};
            mplier_p0 <= {1'b0, mplier_p0[31:1]};
            cnt_p0    <= cnt_p0 - 5'd1;
        end
    end
`else
    logic unused_mul;

    assign unused_mul = mul_i;
    assign idle       = 1'b1;
    assign alu_acc    = accept;
    assign mul_done   = 1'b0;
    assign mul_fwe    = 1'b0;
    assign mul_out    = '0;
`endif

    // ---- stage p1: output slot and architectural flags ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            out_p1   <= '0;
            flags_p1 <= 4'd0;
        end else if (flush_i) begin
            vld_p1   <= 1'b0;
        end else if (alu_acc) begin
            vld_p1   <= 1'b1;
            out_p1   <= {alu.res, data_i.rd, data_i.we1, data_i.we2};
            if (data_i.ctl.fwe)
                flags_p1 <= flags_next(flags_p1, alu.res, data_i.ctl.opr == 2'd0, alu.c, alu.v);
        end else if (mul_done) begin
            vld_p1   <= 1'b1;
            out_p1   <= mul_out;
            if (mul_fwe)
                flags_p1 <= flags_next(flags_p1, mul_out.res, 1'b0, 1'b0, 1'b0);
        end else if (vld_p1 & ready_i) begin
            vld_p1   <= 1'b0;
        end
    end

    assign valid_o = vld_p1;
    assign data_o  = out_p1;
    assign rd3_o   = out_p1.rd;
    assign stl3_o  = vld_p1 & out_p1.we1;
    assign flags_o = flags_p1;
endmodule

// File: tb/tb_hs32_execute.sv
// Scoreboard bench for hs32_execute: driver pushes model results, monitor pops on handshake.
module tb_hs32_execute;
    import hs32_pkg::*;

    logic       clk = 1'b0;
    logic       reset, valid_i, ready_o, mul_i, flush_i, valid_o, ready_i, stl3_o;
    hs32_s2pkt  data_i;
    hs32_s3pkt  data_o;
    logic [3:0] rd3_o, flags_o;

    always #5 clk = ~clk;

    hs32_execute dut (
        .clk(clk), .reset(reset), .valid_i(valid_i), .ready_o(ready_o), .data_i(data_i),
        .mul_i(mul_i), .flush_i(flush_i), .valid_o(valid_o), .ready_i(ready_i),
        .data_o(data_o), .rd3_o(rd3_o), .stl3_o(stl3_o), .flags_o(flags_o)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  rd;
        logic        we1;
        logic        we2;
        logic [3:0]  flags;
        logic        is_mul;
    } exp_t;

    exp_t       sbq[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] mflags;
    logic       mul_pend;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic hs32_s2pkt mk(input logic [31:0] d1, input logic [31:0] d2, input logic [3:0] rd,
                                     input logic neg, input logic sub, input logic cen,
                                     input logic [1:0] opr, input logic fwe);
        hs32_s2pkt p;
        p.d1 = d1; p.d2 = d2; p.rd = rd; p.we1 = 1'b1; p.we2 = 1'b0;
        p.ctl.neg = neg; p.ctl.sub = sub; p.ctl.cen = cen; p.ctl.opr = opr; p.ctl.fwe = fwe;
        return p;
    endfunction

    // Reference model: plain wide arithmetic; flags kept as {N,Z,C,V}.
    task automatic model_accept(input hs32_s2pkt p, input logic m);
        logic [31:0]     bv;
        longint unsigned usum;
        longint          ssum;
        exp_t            e;
        bit              n, z, c, v;
        bv = p.ctl.neg ? ~p.d2 : p.d2;
        c = mflags[1];
        v = mflags[0];
        e.is_mul = 1'b0;
`ifdef HS32_EX_MUL_EN
        if (m) begin
            e.res = 32'(longint'(p.d1) * longint'(p.d2));
            e.is_mul = 1'b1;
            mul_pend = 1'b1;
        end else
`endif
        begin
            usum = longint'(p.d1) + longint'(bv) + longint'(p.ctl.cen ? mflags[1] : p.ctl.sub);
            ssum = longint'($signed(p.d1)) + longint'($signed(bv)) + longint'(p.ctl.cen ? mflags[1] : p.ctl.sub);
            case (p.ctl.opr)
                2'd0: begin
                    e.res = usum[31:0];
                    c = usum >= 64'h1_0000_0000;
                    v = (ssum > 64'sd2147483647) || (ssum < -64'sd2147483648);
                end
                2'd1: e.res = p.d1 & bv;
                2'd2: e.res = p.d1 | bv;
                default: e.res = p.d1 ^ bv;
            endcase
        end
        n = e.res[31];
        z = (e.res == 0);
        if (p.ctl.fwe) mflags = {n, z, c, v};
        e.rd = p.rd; e.we1 = p.we1; e.we2 = p.we2; e.flags = mflags;
        sbq.push_back(e);
    endtask

    // One cycle of stimulus: inputs change 1 time unit after the edge.
    task automatic drive(input logic v, input hs32_s2pkt p, input logic m, input logic rdy, input logic fl);
        @(posedge clk); #1;
        valid_i = v; data_i = p; mul_i = m; ready_i = rdy; flush_i = fl;
        #1;
        if (!mul_pend) check("ready_o", ready_o, !mul_pend && (sbq.size() == 0 || rdy));
        if (fl) begin
            sbq.delete();
            mul_pend = 1'b0;
        end else if (v && ready_o) begin
            model_accept(p, m);
        end
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, '0, 1'b0, rdy, 1'b0);
    endtask

    // Monitor: compare against the scoreboard head on each writeback handshake.
    always @(negedge clk) begin
        if (!reset && valid_o && ready_i) begin
            if (sbq.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (e.is_mul) mul_pend = 1'b0;
                check("res", data_o.res, e.res);
                check("rd_we", {data_o.rd, data_o.we1, data_o.we2}, {e.rd, e.we1, e.we2});
                check("fwd", {rd3_o, stl3_o}, {e.rd, e.we1});
                check("flags", flags_o, e.flags);
            end
        end
    end

    hs32_s3pkt held;
    int        lat;

    initial begin
        reset = 1'b1; valid_i = 1'b0; data_i = '0; mul_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
        mflags = 4'd0; mul_pend = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_flags", flags_o, 4'b0000);
        check("rst_ready", ready_o, 1);
        check("rst_data", data_o, 0);

        drive(1, mk(32'h7FFFFFFF, 32'd1, 4'd1, 0, 0, 0, 2'd0, 1), 0, 1, 0);
        idle(1);
        check("adds_res", data_o.res, 32'h80000000);
        check("adds_flags", flags_o, 4'b1001);

        drive(1, mk(32'd5, 32'd5, 4'd2, 1, 1, 0, 2'd0, 1), 0, 1, 0);
        idle(1);
        check("subs_res", data_o.res, 32'd0);
        check("subs_flags", flags_o, 4'b0110);

        drive(1, mk(32'hFFFFFFFF, 32'd1, 4'd4, 0, 0, 0, 2'd0, 1), 0, 1, 0);
        drive(1, mk(32'd0, 32'd0, 4'd5, 0, 0, 1, 2'd0, 0), 0, 1, 0);
        check("chain_nobubble", ready_o, 1);
        check("chain_res0", data_o.res, 32'd0);
        idle(1);
        check("chain_res1", data_o.res, 32'd1);

        drive(1, mk(32'h12345678, 32'h0F0F0F0F, 4'd3, 0, 0, 0, 2'd1, 1), 0, 1, 0);
        drive(1, mk(32'd9, 32'd1, 4'd6, 0, 0, 0, 2'd0, 1), 0, 0, 0);
        check("bp_ready", ready_o, 0);
        check("bp_fwd", {stl3_o, rd3_o}, {1'b1, 4'd3});
        held = data_o;
        drive(1, mk(32'd9, 32'd1, 4'd6, 0, 0, 0, 2'd0, 1), 0, 0, 0);
        check("bp_hold", data_o, held);
        check("bp_flags", flags_o, mflags);
        drive(1, mk(32'd9, 32'd1, 4'd6, 0, 0, 0, 2'd0, 1), 0, 1, 0);
        check("bp_release", ready_o, 1);
        idle(1);
        check("bp_next_res", data_o.res, 32'd10);

        drive(1, mk(32'hF0F0F0F0, 32'h0000FFFF, 4'd7, 0, 0, 0, 2'd2, 1), 0, 1, 0);
        idle(0);
        drive(0, '0, 0, 0, 1);
        idle(1);
        check("flush_valid", valid_o, 0);
        check("flush_flags", flags_o, mflags);

`ifdef HS32_EX_MUL_EN
        drive(1, mk(32'h00010001, 32'h00010001, 4'd8, 0, 0, 0, 2'd0, 1), 1, 1, 0);
        lat = 0;
        for (int i = 0; i < 60 && !valid_o; i++) begin
            idle(1);
            lat++;
        end
        check("mul_latency", lat, 33);
        check("mul_res", data_o.res, 32'h00020001);
        check("mul_flags", flags_o, mflags);
        idle(1);
        drive(1, mk(32'd3, 32'd4, 4'd9, 0, 0, 0, 2'd0, 1), 1, 1, 0);
        repeat (9) idle(1);
        drive(0, '0, 0, 0, 1);
        idle(1);
        check("mulflush_ready", ready_o, 1);
        check("mulflush_valid", valid_o, 0);
`else
        drive(1, mk(32'h00010001, 32'h00010001, 4'd8, 0, 0, 0, 2'd0, 1), 1, 1, 0);
        idle(1);
        check("nomul_res", data_o.res, 32'h00020002);
`endif

        for (int i = 0; i < 600; i++) begin
            hs32_s2pkt p;
            logic      fl, m;
            logic [31:0] w[4];
            w[0] = 32'd0; w[1] = 32'hFFFFFFFF; w[2] = 32'h7FFFFFFF; w[3] = 32'h80000000;
            p = hs32_s2pkt'({$urandom(), $urandom(), $urandom()});
            if ($urandom_range(0, 3) == 0) p.d1 = w[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) p.d2 = w[$urandom_range(0, 3)];
            fl = ($urandom_range(0, 39) == 0);
`ifdef HS32_EX_MUL_EN
            m = ($urandom_range(0, 29) == 0);
`else
            m = ($urandom_range(0, 9) == 0);
`endif
            drive($urandom_range(0, 9) < 7, p, m, fl ? 1'b0 : ($urandom_range(0, 3) != 0), fl);
        end

        for (int i = 0; i < 100 && sbq.size() != 0; i++) idle(1);
        check("drain_empty", sbq.size(), 0);
        idle(1);
        check("drain_valid", valid_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
